// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: serial pattern scanner that counts hits of a latched
// PAT_W-bit pattern on a valid-qualified bit stream and ends a run
// when the hit target is reached or the run is stopped.
//
// Ports:
//   clk, rst (async, active-low)
//   cfg_pattern/cfg_overlap/cfg_hits/cfg_timeout : run setup, latched on start
//   start, stop                                  : run control
//   din, din_valid                               : serial input
//   detected, hit_count, busy, done, timeout     : status
//
// Build option: define SEQ_TIMEOUT_EN to add the inter-hit timeout
// counter; otherwise timeout is tied low and cfg_timeout is ignored.
module seq_scan_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TO_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_hits,
    input  logic [TO_W-1:0]  cfg_timeout,
    input  logic             start,
    input  logic             stop,
    input  logic             din,
    input  logic             din_valid,
    output logic             detected,
    output logic [CNT_W-1:0] hit_count,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             ovl_q, ovl_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [PAT_W-1:0] shift_q, shift_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic             detected_q, detected_d;
    logic             done_q, done_d;

    logic [PAT_W-1:0] shift_nx;
    logic [FW-1:0]    fill_nx;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] tgt_eff;
    logic             hit;

`ifdef SEQ_TIMEOUT_EN
    logic [TO_W-1:0] lim_q, lim_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [TO_W-1:0] to_inc;
    logic            timeout_q, timeout_d;
`else
    logic unused_cfg_timeout;
    assign unused_cfg_timeout = ^cfg_timeout;
`endif

    // Candidate values for this sample; committed only when din_valid.
    assign shift_nx = {shift_q[PAT_W-2:0], din};
    assign fill_nx  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    assign hit      = (fill_nx == FILL_FULL) && (shift_nx == pat_q);
    assign cnt_inc  = (hit_count_q == CNT_MAX) ? hit_count_q
                                               : hit_count_q + 1'b1;
    // A target of zero behaves like a target of one.
    assign tgt_eff  = (tgt_q == '0) ? CNT_W'(1) : tgt_q;
`ifdef SEQ_TIMEOUT_EN
    assign to_inc   = to_cnt_q + 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        ovl_d       = ovl_q;
        tgt_d       = tgt_q;
        shift_d     = shift_q;
        fill_d      = fill_q;
        hit_count_d = hit_count_q;
        detected_d  = 1'b0;
        done_d      = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        lim_d       = lim_q;
        to_cnt_d    = to_cnt_q;
        timeout_d   = timeout_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ARMED;
                    pat_d       = cfg_pattern;
                    ovl_d       = cfg_overlap;
                    tgt_d       = cfg_hits;
                    shift_d     = '0;
                    fill_d      = '0;
                    hit_count_d = '0;
`ifdef SEQ_TIMEOUT_EN
                    lim_d       = cfg_timeout;
                    to_cnt_d    = '0;
                    timeout_d   = 1'b0;
`endif
                end
            end
            S_ARMED: begin
                // Stop wins over any hit or timeout in the same cycle.
                if (stop) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end else if (din_valid) begin
                    shift_d = shift_nx;
                    fill_d  = fill_nx;
                    if (hit) begin
                        detected_d  = 1'b1;
                        hit_count_d = cnt_inc;
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
`ifdef SEQ_TIMEOUT_EN
                        to_cnt_d = '0;
`endif
                        if (cnt_inc == tgt_eff) begin
                            state_d = S_FINISH;
                            done_d  = 1'b1;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else begin
                        to_cnt_d = to_inc;
                        if (lim_q != '0 && to_inc == lim_q) begin
                            state_d   = S_FINISH;
                            done_d    = 1'b1;
                            timeout_d = 1'b1;
                        end
                    end
`endif
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            ovl_q       <= 1'b0;
            tgt_q       <= '0;
            shift_q     <= '0;
            fill_q      <= '0;
            hit_count_q <= '0;
            detected_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            ovl_q       <= ovl_d;
            tgt_q       <= tgt_d;
            shift_q     <= shift_d;
            fill_q      <= fill_d;
            hit_count_q <= hit_count_d;
            detected_q  <= detected_d;
            done_q      <= done_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lim_q     <= '0;
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            lim_q     <= lim_d;
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign detected  = detected_q;
    assign hit_count = hit_count_q;
    assign busy      = (state_q == S_ARMED);
    assign done      = done_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: directed scenarios plus randomized runs
// checked every cycle against a queue-based reference model.
module tb_seq_scan_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int TO_W  = 8;
`ifdef SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic             cfg_overlap = 1'b0;
    logic [CNT_W-1:0] cfg_hits = '0;
    logic [TO_W-1:0]  cfg_timeout = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             detected;
    logic [CNT_W-1:0] hit_count;
    logic             busy;
    logic             done;
    logic             timeout;

    seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
        .cfg_hits(cfg_hits), .cfg_timeout(cfg_timeout),
        .start(start), .stop(stop), .din(din), .din_valid(din_valid),
        .detected(detected), .hit_count(hit_count), .busy(busy),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: run phase plus the raw history of valid bits
    // that can still contribute to a match.
    typedef enum int {P_IDLE, P_RUN, P_END} phase_t;
    phase_t m_ph = P_IDLE;
    bit     hist[$];
    int     m_pat, m_tgt, m_lim, m_since, m_hits;
    bit     m_ovl, m_det, m_done, m_tmo;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ph = P_IDLE;
        hist.delete();
        m_since = 0; m_hits = 0;
        m_det = 0; m_done = 0; m_tmo = 0;
    endtask

    function automatic bit tail_match();
        int v = 0;
        if (hist.size() < PAT_W) return 0;
        for (int i = hist.size() - PAT_W; i < hist.size(); i++)
            v = (v << 1) | int'(hist[i]);
        return v == m_pat;
    endfunction

    task automatic model_edge();
        m_det = 0; m_done = 0;
        case (m_ph)
            P_IDLE: if (start) begin
                m_ph = P_RUN;
                m_pat = int'(cfg_pattern); m_ovl = cfg_overlap;
                m_tgt = (cfg_hits == 0) ? 1 : int'(cfg_hits);
                m_lim = int'(cfg_timeout);
                hist.delete(); m_since = 0; m_hits = 0; m_tmo = 0;
            end
            P_RUN: if (stop) begin
                m_ph = P_END; m_done = 1;
            end else if (din_valid) begin
                hist.push_back(din);
                if (hist.size() > PAT_W) void'(hist.pop_front());
                m_since++;
                if (tail_match()) begin
                    m_det = 1;
                    if (m_hits < (1 << CNT_W) - 1) m_hits++;
                    if (!m_ovl) hist.delete();
                    m_since = 0;
                    if (m_hits == m_tgt) begin
                        m_ph = P_END; m_done = 1;
                    end
                end else if (TO_EN && m_lim != 0 && m_since == m_lim) begin
                    m_ph = P_END; m_done = 1; m_tmo = 1;
                end
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".detected"}, 32'(detected), 32'(m_det));
        check({tag, ".hit_count"}, 32'(hit_count), 32'(m_hits));
        check({tag, ".busy"}, 32'(busy), 32'(m_ph == P_RUN));
        check({tag, ".done"}, 32'(done), 32'(m_done));
        check({tag, ".timeout"}, 32'(timeout), 32'(m_tmo));
    endtask

    task automatic step(input logic s_start, input logic s_stop,
                        input logic s_din, input logic s_valid,
                        input string tag);
        start = s_start; stop = s_stop; din = s_din; din_valid = s_valid;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Send n valid bits MSB first; mask marks where detected is expected.
    task automatic send(input logic [15:0] bits, input int n,
                        input logic [15:0] mask, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b0, 1'b0, bits[i], 1'b1, tag);
            check({tag, ".det_pos"}, 32'(detected), 32'(mask[i]));
        end
    endtask

    task automatic setup(input logic [3:0] p, input logic o,
                         input logic [7:0] h, input logic [7:0] t);
        cfg_pattern = p; cfg_overlap = o; cfg_hits = h; cfg_timeout = t;
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, "idle");

        // Non-overlapping run.
        setup(4'b1011, 1'b0, 8'd2, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, "nov.start");
        setup(4'b0000, 1'b1, 8'd9, 8'd1);
        send(16'b101_1011_1011, 11, 16'b000_1000_0001, "nov");
        check("nov.done", 32'(done), 32'd1);
        check("nov.count", 32'(hit_count), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, "nov.idle");
        check("nov.hold", 32'(hit_count), 32'd2);

        // Overlapping run on the same stream.
        setup(4'b1011, 1'b1, 8'd3, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, "ovl.start");
        send(16'b101_1011_1011, 11, 16'b000_1001_0001, "ovl");
        check("ovl.done", 32'(done), 32'd1);
        check("ovl.count", 32'(hit_count), 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, "ovl.idle");

        // Valid gaps: one pulse right after the fourth valid bit.
        setup(4'b1011, 1'b0, 8'd0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, "gap.start");
        step(1'b0, 1'b0, 1'b1, 1'b1, "gap");
        step(1'b0, 1'b0, 1'b1, 1'b0, "gap");
        step(1'b0, 1'b0, 1'b0, 1'b1, "gap");
        step(1'b0, 1'b0, 1'b1, 1'b0, "gap");
        step(1'b0, 1'b0, 1'b0, 1'b0, "gap");
        step(1'b0, 1'b0, 1'b1, 1'b1, "gap");
        check("gap.nodet", 32'(detected), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, "gap");
        step(1'b0, 1'b0, 1'b1, 1'b1, "gap");
        check("gap.det", 32'(detected), 32'd1);
        check("gap.done", 32'(done), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, "gap.idle");

        // Stop collides with the completing bit of a second hit.
        setup(4'b1011, 1'b0, 8'd2, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, "stp.start");
        send(16'b1011_101, 7, 16'b0001_000, "stp");
        step(1'b0, 1'b1, 1'b1, 1'b1, "stp.col");
        check("stp.nodet", 32'(detected), 32'd0);
        check("stp.count", 32'(hit_count), 32'd1);
        check("stp.done", 32'(done), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, "stp.fin_start");
        check("stp.ignored", 32'(busy), 32'd0);

        // Asynchronous reset mid-run.
        setup(4'b1011, 1'b0, 8'd3, 8'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, "rst.start");
        send(16'b1011, 4, 16'b0001, "rst");
        step(1'b0, 1'b0, 1'b0, 1'b0, "rst.pre");
        check("rst.pre_cnt", 32'(hit_count), 32'd1);
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("rst.async");
        @(posedge clk); #1;
        check_all("rst.held");
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b1, "rst.after");
        step(1'b0, 1'b0, 1'b0, 1'b0, "rst.after");
        check("rst.nobusy", 32'(busy), 32'd0);

        // Timeout on a stream of zeros.
        setup(4'b1011, 1'b0, 8'd1, 8'd5);
        step(1'b1, 1'b0, 1'b0, 1'b0, "to.start");
        send(16'b00000, 5, 16'b0, "to");
        check("to.done", 32'(done), 32'(TO_EN));
        check("to.flag", 32'(timeout), 32'(TO_EN));
        check("to.count", 32'(hit_count), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, "to.stop");
        step(1'b0, 1'b0, 1'b0, 1'b0, "to.idle");
        check("to.sticky", 32'(timeout), 32'(TO_EN));

        // Randomized runs, cfg scrambled every cycle to exercise latching.
        for (int c = 0; c < 3000; c++) begin
            logic r_start, r_stop, r_din, r_val;
            cfg_pattern = 4'($urandom);
            cfg_overlap = 1'($urandom);
            cfg_hits    = 8'($urandom_range(0, 4));
            cfg_timeout = 8'($urandom_range(0, 12));
            r_start = ($urandom_range(0, 3) == 0);
            r_stop  = ($urandom_range(0, 59) == 0);
            r_din   = 1'($urandom);
            r_val   = ($urandom_range(0, 3) != 0);
            step(r_start, r_stop, r_din, r_val, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..8.
REQ-002 Parameter CNT_W, default 8: width of the hit target and the hit counter.
REQ-003 Parameter TO_W, default 8: width of the timeout limit (used only with SEQ_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 cfg_pattern  input  PAT_W  target pattern; MSB is the oldest bit.
REQ-007 cfg_overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-008 cfg_hits  input  CNT_W  number of hits required to finish a run; 0 is treated as 1.
REQ-009 cfg_timeout  input  TO_W  maximum valid samples allowed between hits.
REQ-010 start  input  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-011 stop  input  1  abort request; honoured in ARMED.
REQ-012 din  input  1  serial data bit.
REQ-013 din_valid  input  1  din is sampled only when this is 1.
REQ-014 detected  output  1  one-cycle pulse per hit; registered.
REQ-015 hit_count  output  CNT_W  hits counted in the current or last run.
REQ-016 busy  output  1  high while in ARMED.
REQ-017 done  output  1  one-cycle pulse when a run completes or aborts.
REQ-018 timeout  output  1  sticky flag: last run ended by timeout.

Function
REQ-019 The FSM SHALL have three states: IDLE, ARMED, FINISH.
REQ-020 IDLE->ARMED on start, which SHALL:
- latch cfg_pattern, cfg_overlap, cfg_hits, cfg_timeout;
- clear the shift register, fill counter, hit_count and timeout.
REQ-021 cfg_* changes while ARMED SHALL have no effect on the run in progress.
REQ-022 In ARMED, each cycle with din_valid=1 SHALL:
- shift din into the PAT_W-bit shift register at the LSB;
- increment the fill counter, saturating at PAT_W.
REQ-023 A hit SHALL be declared in the same cycle the new bit is shifted in, when both hold:
- fill counter (after the update) equals PAT_W;
- shifted value equals the latched pattern.
REQ-024 On a hit:
- detected SHALL be 1 in the following cycle only;
- hit_count SHALL increment, saturating at all-ones.
REQ-025 Overlap handling on a hit:
- cfg_overlap=1: the fill counter is retained;
- cfg_overlap=0: the fill counter clears to 0, so the next hit needs PAT_W fresh bits.
REQ-026 With din_valid=0, no shift, fill, hit or timeout-count update SHALL occur.
REQ-027 ARMED->FINISH when hit_count reaches the latched target (target 0 treated as 1).
REQ-028 ARMED->FINISH on stop; stop SHALL take priority over a hit in the same cycle, so that hit is not counted.
REQ-029 FINISH SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-030 hit_count SHALL hold its value in IDLE until the next start.
REQ-031 start in ARMED or FINISH SHALL be ignored.
REQ-032 busy SHALL equal (state==ARMED).
REQ-033 Latency: a bit sampled at edge N produces detected=1 during cycle N+1; done follows the completing hit by one cycle.

Reset
REQ-034 rst low SHALL asynchronously force:
- state to IDLE;
- shift register, fill counter, hit_count and timeout counter to 0;
- detected, done, timeout and busy to 0.
REQ-035 Reset asserted mid-run SHALL abort the run without a done pulse.
REQ-036 Release of rst SHALL take effect at the next rising clk edge; no run starts without a new start.

Configuration
REQ-037 Macro SEQ_TIMEOUT_EN, when defined, enables timeout:
- a TO_W counter counts valid samples since the last hit or start;
- when the count reaches cfg_timeout (nonzero) with no hit, the FSM SHALL go ARMED->FINISH and set timeout=1;
- cfg_timeout=0 disables the check.
REQ-038 Timeout precedence: stop > hit > timeout in the same cycle.
REQ-039 Without SEQ_TIMEOUT_EN: no timeout counter is built, timeout is tied 0, and cfg_timeout is ignored; the port list is identical in both builds.

Verification
REQ-040 Non-overlap run:
- PAT_W=4, pattern 1011, overlap=0, hits=2;
- stream 1011011 then 1011;
- detected at bits 4 and 11 only; done one cycle after the second hit; hit_count=2.
REQ-041 Overlap run:
- same stream, overlap=1, hits=3;
- detected at bits 4, 7 and 11; done after bit 11.
REQ-042 din_valid gaps:
- pattern 1011 with din_valid=0 cycles interleaved;
- exactly one detected pulse, one cycle after the fourth valid bit.
REQ-043 Stop priority:
- stop asserted in the same cycle as the completing bit of a hit;
- no detected pulse; hit_count unchanged; done=1 next cycle.
REQ-044 Reset mid-run:
- rst low while ARMED with hit_count=1;
- all outputs 0 immediately, asynchronously; no done pulse; restart needs start.
REQ-045 Timeout (SEQ_TIMEOUT_EN defined):
- cfg_timeout=5, stream of 0s;
- after 5 valid samples, done=1 and timeout=1 with hit_count=0;
- in a build without the macro, timeout stays 0 throughout.
